// File: rtl/sram_arb_mmu.sv
// Round-robin arbiter sharing one single-port SRAM among NCH requesters, one transfer per cycle.
// Optional MIPS kseg0/kseg1 address mapping enabled by defining SRAM_ARB_MMU_MAP_EN.
module sram_arb_mmu #(
    parameter int unsigned NCH = 2,
    parameter int unsigned DW  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [4*NCH-1:0]  req_wen,
    input  logic [32*NCH-1:0] req_addr,
    input  logic [DW*NCH-1:0] req_wdata,
    output logic [NCH-1:0]    rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [31:0]       sram_addr,
    output logic [DW-1:0]     sram_wdata,
    input  logic [DW-1:0]     sram_rdata
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_idx, cand;
    logic          gnt;
    logic [31:0]   va;

    logic          pend_valid_q;
    logic          pend_read_q;
    logic [IW-1:0] pend_ch_q;

    // First requesting channel at or above ptr, wrapping around.
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = IW'((int'(ptr_q) + k) % NCH);
            if (!gnt && !rst && req_valid[cand]) begin
                gnt     = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sram_en    = gnt;
        sram_wen   = '0;
        va         = '0;
        sram_wdata = '0;
        if (gnt) begin
            sram_wen   = req_wen[4*gnt_idx +: 4];
            va         = req_addr[32*gnt_idx +: 32];
            sram_wdata = req_wdata[DW*gnt_idx +: DW];
        end
    end

`ifdef SRAM_ARB_MMU_MAP_EN
    // va[31:30] == 2'b10 covers both kseg0 (100) and kseg1 (101).
    assign sram_addr = (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
`else
    assign sram_addr = va;
`endif

    assign ptr_d = gnt ? IW'((int'(gnt_idx) + 1) % NCH) : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_read_q  <= 1'b0;
            pend_ch_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            pend_valid_q <= gnt;
            if (gnt) begin
                pend_ch_q   <= gnt_idx;
                pend_read_q <= (sram_wen == 4'b0000);
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (pend_valid_q && !rst) begin
            rsp_valid[pend_ch_q] = 1'b1;
            if (pend_read_q) begin
                rsp_rdata = sram_rdata;
            end
        end
    end

endmodule

// File: doc/sram_arb_mmu.md
SRAM_ARB_MMU -- requirements
Module: sram_arb_mmu

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 Parameter NCH, default 2: number of requester channels, legal range 1..8.
REQ-003 Parameter DW, default 32: data width; the address width is fixed at 32.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 req_valid  in  NCH: per-channel request strobe.
REQ-007 req_ready  out  NCH: per-channel grant, one-hot or zero.
REQ-008 req_wen  in  4*NCH: per-channel byte write enables; 0 means read.
REQ-009 req_addr  in  32*NCH: per-channel virtual address.
REQ-010 req_wdata  in  DW*NCH: per-channel write data.
REQ-011 rsp_valid  out  NCH: per-channel response strobe.
REQ-012 rsp_rdata  out  DW: read data, shared by all channels and qualified by rsp_valid.
REQ-013 sram_en  out  1: SRAM enable.
REQ-014 sram_wen  out  4: SRAM byte write enables.
REQ-015 sram_addr  out  32: physical SRAM address.
REQ-016 sram_wdata  out  DW: SRAM write data.
REQ-017 sram_rdata  in  DW: SRAM read data, valid one cycle after sram_en.

Function
REQ-018 Grant: a channel is transferred in a cycle when req_valid[i] and req_ready[i] are both 1.
- req_ready is combinational from req_valid and the round-robin pointer.
- At most one bit of req_ready is set per cycle.
- No channel is granted while rst is high.
REQ-019 Arbitration: round-robin, searching upward from pointer ptr with wrap-around.
- After a transfer on channel i, ptr = (i+1) mod NCH.
- ptr is unchanged in cycles with no transfer.
REQ-020 SRAM issue: in a transfer cycle, drive the granted channel's request onto the SRAM port combinationally.
- sram_en=1; sram_wen, sram_addr (mapped) and sram_wdata from the granted channel.
- With no transfer: sram_en=0 and sram_wen=0.
REQ-021 Pipeline register: a transfer loads pend_valid=1 and pend_ch=i; otherwise pend_valid loads 0.
- Back-to-back transfers are allowed every cycle, giving throughput of 1 per cycle.
REQ-022 Response: rsp_valid[pend_ch]=1 exactly one cycle after the transfer, for reads and writes alike.
- rsp_rdata = sram_rdata during a read response.
- rsp_rdata = 0 during a write response and during idle cycles.
REQ-023 Request stability: the requester holds req_* stable until granted; the block never drops or duplicates a transfer.
REQ-024 NCH=1: the arbiter degenerates to req_ready = req_valid and ptr stays 0.

Reset
REQ-025 While rst is high, all of the following SHALL hold:
- req_ready=0, rsp_valid=0, rsp_rdata=0.
- sram_en=0, sram_wen=0, sram_addr=0, sram_wdata=0.
- ptr=0, pend_valid=0.
REQ-026 Reset asserted mid-operation SHALL discard any pending response; no rsp_valid is produced after reset deasserts.
REQ-027 The first cycle after reset deasserts SHALL grant the lowest-indexed requesting channel.

Configuration
REQ-028 Macro SRAM_ARB_MMU_MAP_EN controls MIPS segment mapping of the SRAM address.
- Defined, for va[31:29]:
  - 3'b100 (kseg0) or 3'b101 (kseg1): sram_addr = {3'b000, va[28:0]}.
  - Any other value: sram_addr = va.
- Undefined: sram_addr = va unmodified.

Verification
REQ-029 Channel 0 read 0xBFC0_0000, SRAM returns 0x1234_5678; MAP_EN defined -> sram_addr=0x1FC0_0000, then rsp_valid[0]=1 and rsp_rdata=0x1234_5678 one cycle later.
REQ-030 Channels 0 and 1 both valid continuously for 4 cycles, from reset -> grants 0,1,0,1 and responses 0,1,0,1, each lagging its grant by one cycle.
REQ-031 Channel 1 write wen=4'b0011, addr 0x8000_0010, data 0xDEAD_BEEF -> sram_wen=0011, sram_addr=0x0000_0010, sram_wdata=0xDEAD_BEEF, next cycle rsp_valid[1]=1 with rsp_rdata=0.
REQ-032 rst asserted on the cycle after a channel 0 read is granted -> rsp_valid stays 0 and, after release, ptr=0.
REQ-033 MAP_EN undefined, read 0x8000_0004 -> sram_addr=0x8000_0004.
REQ-034 NCH=4, channels 1 and 3 requesting with ptr=2 -> channel 3 granted first, then channel 1, then ptr=2.
